// File: rtl/tdc_meas_seq.sv
// ----------------------------------------------------------------------------
// tdc_meas_seq
//
// Measurement sequencer for the HSC TDC (tdc_top). A start command kicks off a
// burst of launch/capture cycles. Each sample pulses clk_launch and val_in
// together and flips pg_tog. After a programmable gap it pulses clk_capture.
// It then waits for the TDC to return a hamming-weight result on hw/val_out.
// Collected results are folded into sum / minimum / maximum statistics.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   en             enable; dropping it aborts a run to IDLE (no done pulse)
//   start          begin a run (only honoured in IDLE)
//   n_samples      samples per run (0 is treated as 1)
//   gap_cfg        idle cycles between launch pulse and capture pulse
//   clk_launch     launch pulse to the TDC
//   clk_capture    capture pulse to the TDC
//   val_in         valid flag to the TDC, coincident with clk_launch
//   pg_tog         pattern toggle, flips once per sample
//   hw, val_out    TDC result and its valid strobe
//   busy           a run is in progress
//   done           one-cycle pulse at the normal end of a run
//   err_timeout    the run ended because a result never arrived
//   sum            sum of collected hw values
//   hw_min         smallest collected hw value
//   hw_max         largest collected hw value
//   n_got          number of samples collected in the last run
//
// All outputs come straight from flops. The strobe-type outputs are computed
// from the next state, so they are high for exactly the cycles spent in
// their named state.
// ----------------------------------------------------------------------------
module tdc_meas_seq #(
    parameter int N       = 64,
    parameter int HW_W    = $clog2(N) + 1,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [CNT_W-1:0]      n_samples,
    input  logic [GAP_W-1:0]      gap_cfg,
    output logic                  clk_launch,
    output logic                  clk_capture,
    output logic                  val_in,
    output logic                  pg_tog,
    input  logic [HW_W-1:0]       hw,
    input  logic                  val_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [HW_W+CNT_W-1:0] sum,
    output logic [HW_W-1:0]       hw_min,
    output logic [HW_W-1:0]       hw_max,
    output logic [CNT_W-1:0]      n_got
);

    localparam int SUM_W = HW_W + CNT_W;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GAP,
        S_CAPTURE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Run configuration, latched when a start is accepted
    logic [CNT_W-1:0] count_reg;
    logic [GAP_W-1:0] gap_cfg_reg;

    // Per-sample counters
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Output registers
    logic             clk_launch_reg;
    logic             clk_capture_reg;
    logic             val_in_reg;
    logic             pg_tog_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_timeout_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [HW_W-1:0]  hw_min_reg;
    logic [HW_W-1:0]  hw_max_reg;
    logic [CNT_W-1:0] n_got_reg;

    // Qualified events
    logic accept_start;
    logic take_sample;
    logic tmo_expire;
    logic last_sample;

    assign accept_start = en && (state_reg == S_IDLE) && start;
    assign take_sample  = en && (state_reg == S_WAIT) && val_out;
    // A result arriving in the expiry cycle takes priority over the timeout
    assign tmo_expire   = en && (state_reg == S_WAIT) && !val_out
                          && (tmo_cnt_reg == TMO_LAST);
    assign last_sample  = (n_got_reg + CNT_ONE) == count_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (!en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A zero gap skips GAP entirely: capture lands one cycle
                    // after launch.
                    if (gap_cfg_reg == '0) begin
                        state_next = S_CAPTURE;
                    end else begin
                        state_next = S_GAP;
                    end
                end
                S_GAP: begin
                    // Counter is loaded with gap_cfg (>=1) on entry, so GAP
                    // lasts exactly gap_cfg cycles.
                    if (gap_cnt_reg <= GAP_ONE) begin
                        state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (val_out) begin
                        if (last_sample) begin
                            state_next = S_DONE;
                        end else begin
                            state_next = S_LAUNCH;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg       <= '0;
            gap_cfg_reg     <= '0;
            gap_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            clk_launch_reg  <= 1'b0;
            clk_capture_reg <= 1'b0;
            val_in_reg      <= 1'b0;
            pg_tog_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_timeout_reg <= 1'b0;
            sum_reg         <= '0;
            hw_min_reg      <= '0;
            hw_max_reg      <= '0;
            n_got_reg       <= '0;
        end else begin
            clk_launch_reg  <= (state_next == S_LAUNCH);
            val_in_reg      <= (state_next == S_LAUNCH);
            clk_capture_reg <= (state_next == S_CAPTURE);
            busy_reg        <= (state_next != S_IDLE);
            done_reg        <= (state_next == S_DONE);

            // Flip alongside the rising launch pulse so the TDC sees the new
            // pattern for the sample being launched.
            if (state_next == S_LAUNCH) begin
                pg_tog_reg <= ~pg_tog_reg;
            end

            if (state_reg == S_LAUNCH) begin
                gap_cnt_reg <= gap_cfg_reg;
            end else if (state_reg == S_GAP) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
            end

            if (state_reg == S_CAPTURE) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end

            if (accept_start) begin
                count_reg       <= (n_samples == '0) ? CNT_ONE : n_samples;
                gap_cfg_reg     <= gap_cfg;
                sum_reg         <= '0;
                n_got_reg       <= '0;
                err_timeout_reg <= 1'b0;
                hw_min_reg      <= '1;
                hw_max_reg      <= '0;
            end

            if (take_sample) begin
                sum_reg   <= sum_reg + SUM_W'(hw);
                n_got_reg <= n_got_reg + CNT_ONE;
                if (hw < hw_min_reg) begin
                    hw_min_reg <= hw;
                end
                if (hw > hw_max_reg) begin
                    hw_max_reg <= hw;
                end
            end

            if (tmo_expire) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    assign clk_launch  = clk_launch_reg;
    assign clk_capture = clk_capture_reg;
    assign val_in      = val_in_reg;
    assign pg_tog      = pg_tog_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err_timeout = err_timeout_reg;
    assign sum         = sum_reg;
    assign hw_min      = hw_min_reg;
    assign hw_max      = hw_max_reg;
    assign n_got       = n_got_reg;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// ----------------------------------------------------------------------------
// tb_tdc_meas_seq
//
// Bench for tdc_meas_seq. A behavioural TDC stand-in answers each capture
// pulse with the next queued hw value after a configurable latency (0 = never
// answers). Run records in a table give the stimulus and the expected
// statistics; the expected statistics are queued when a run starts and
// compared when the DUT pulses done. Hand-written sequences cover async
// reset mid-gap, dropping en mid-run, and start/val_out noise during a run.
// ----------------------------------------------------------------------------
module tb_tdc_meas_seq;

    localparam int N       = 64;
    localparam int HW_W    = 7;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int SUM_W   = HW_W + CNT_W;

    logic             clk;
    logic             rst;
    logic             en;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic [GAP_W-1:0] gap_cfg;
    logic             clk_launch;
    logic             clk_capture;
    logic             val_in;
    logic             pg_tog;
    logic [HW_W-1:0]  hw;
    logic             val_out;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [SUM_W-1:0] sum;
    logic [HW_W-1:0]  hw_min;
    logic [HW_W-1:0]  hw_max;
    logic [CNT_W-1:0] n_got;

    tdc_meas_seq #(
        .N       (N),
        .HW_W    (HW_W),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .n_samples   (n_samples),
        .gap_cfg     (gap_cfg),
        .clk_launch  (clk_launch),
        .clk_capture (clk_capture),
        .val_in      (val_in),
        .pg_tog      (pg_tog),
        .hw          (hw),
        .val_out     (val_out),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .sum         (sum),
        .hw_min      (hw_min),
        .hw_max      (hw_max),
        .n_got       (n_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        int g;
        int lat;
        int h0;
        int h1;
        int h2;
        int h3;
        int e_sum;
        int e_min;
        int e_max;
        int e_got;
        int e_err;
        int e_launch;
    } vec_t;

    typedef struct {
        int sum;
        int mn;
        int mx;
        int got;
        int err;
    } exp_t;

    vec_t vt[7];
    exp_t exp_q[$];
    int   resp_q[$];

    int compared;
    int mismatched;
    int cyc;
    int launches;
    int captures;
    int dones;
    int last_launch;
    int last_cap;
    int done_cyc;
    int exp_gap;
    int resp_lat;
    int resp_cnt;
    bit stray_en;
    bit stray_pending;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: observe DUT outputs at the falling edge, then drive
    // the TDC stand-in for the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (clk_launch || val_in) begin
            chk("val_in_with_launch", int'(val_in), int'(clk_launch));
        end
        if (clk_launch) begin
            launches++;
            last_launch = cyc;
        end
        if (clk_capture) begin
            captures++;
            last_cap = cyc;
            chk("capture_delay", cyc - last_launch, exp_gap + 1);
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("run done: sum=%0d min=%0d max=%0d n_got=%0d err=%0d",
                         sum, hw_min, hw_max, n_got, err_timeout);
                chk("sum", int'(sum), e.sum);
                chk("hw_min", int'(hw_min), e.mn);
                chk("hw_max", int'(hw_max), e.mx);
                chk("n_got", int'(n_got), e.got);
                chk("err_timeout", int'(err_timeout), e.err);
            end
        end
        val_out = 1'b0;
        if (stray_pending) begin
            val_out       = 1'b1;
            hw            = 7'd127;
            stray_pending = 1'b0;
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                val_out = 1'b1;
                if (resp_q.size() > 0) begin
                    hw = HW_W'(resp_q.pop_front());
                end else begin
                    hw = '0;
                end
            end
        end
        if (clk_capture && resp_lat > 0) begin
            resp_cnt = resp_lat;
        end
        if (clk_launch && stray_en) begin
            stray_pending = 1'b1;
        end
    endtask

    task automatic setup_model(input vec_t v, input bit stray);
        int hv[4];
        int n_eff;
        hv[0] = v.h0;
        hv[1] = v.h1;
        hv[2] = v.h2;
        hv[3] = v.h3;
        n_eff = (v.n == 0) ? 1 : v.n;
        resp_q.delete();
        for (int i = 0; i < n_eff && i < 4; i++) begin
            resp_q.push_back(hv[i]);
        end
        resp_lat      = v.lat;
        resp_cnt      = 0;
        exp_gap       = v.g;
        stray_en      = stray;
        stray_pending = 1'b0;
    endtask

    task automatic do_run(input vec_t v, input bit stray, input bit spam);
        int   l0;
        int   d0;
        int   cnt;
        logic pg0;
        exp_t e;
        setup_model(v, stray);
        e.sum = v.e_sum;
        e.mn  = v.e_min;
        e.mx  = v.e_max;
        e.got = v.e_got;
        e.err = v.e_err;
        exp_q.push_back(e);
        $display("run: n_samples=%0d gap=%0d lat=%0d stray=%0d spam=%0d",
                 v.n, v.g, v.lat, stray, spam);
        n_samples = CNT_W'(v.n);
        gap_cfg   = GAP_W'(v.g);
        l0        = launches;
        d0        = dones;
        pg0       = pg_tog;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (dones == d0 && cnt < 2000) begin
            if (spam) begin
                start = 1'($urandom_range(0, 1));
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        if (dones == d0) begin
            chk("run_finish_bound", 0, 1);
            exp_q.delete();
        end else begin
            chk("launch_count", launches - l0, v.e_launch);
            chk("pg_tog_parity", int'(pg_tog), int'(pg0 ^ 1'((launches - l0) % 2)));
            if (v.e_err != 0) begin
                chk("timeout_done_delay", done_cyc - last_cap, TIMEOUT + 1);
            end
        end
        tick();
        tick();
        chk("done_once", dones - d0, 1);
        chk("idle_after_run", int'(busy), 0);
    endtask

    initial begin
        int l0;
        int d0;
        int c0;
        int cnt;

        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        launches      = 0;
        captures      = 0;
        dones         = 0;
        last_launch   = 0;
        last_cap      = 0;
        done_cyc      = 0;
        exp_gap       = 0;
        resp_lat      = 0;
        resp_cnt      = 0;
        stray_en      = 1'b0;
        stray_pending = 1'b0;

        rst       = 1'b1;
        en        = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        gap_cfg   = '0;
        val_out   = 1'b0;
        hw        = '0;

        //          n  g  lat h0   h1  h2  h3  sum  min  max got err launch
        vt[0] = '{4, 2,  2, 10,  20,  5, 40,  75,   5,  40, 4, 0, 4};
        vt[1] = '{0, 0,  1, 33,   0,  0,  0,  33,  33,  33, 1, 0, 1};
        vt[2] = '{0, 3,  0,  0,   0,  0,  0,   0, 127,   0, 0, 1, 1};
        vt[3] = '{3, 1,  5, 64,   0,  7,  0,  71,   0,  64, 3, 0, 3};
        vt[4] = '{1, 0, 16, 127,  0,  0,  0, 127, 127, 127, 1, 0, 1};
        vt[5] = '{2, 2, 17, 50,  60,  0,  0,   0, 127,   0, 0, 1, 1};
        vt[6] = '{2, 15, 3, 100,  1,  0,  0, 101,   1, 100, 2, 0, 2};

        tick();
        tick();
        $display("reset state check");
        chk("rst_clk_launch", int'(clk_launch), 0);
        chk("rst_clk_capture", int'(clk_capture), 0);
        chk("rst_val_in", int'(val_in), 0);
        chk("rst_pg_tog", int'(pg_tog), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_hw_min", int'(hw_min), 0);
        chk("rst_hw_max", int'(hw_max), 0);
        chk("rst_n_got", int'(n_got), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // Asynchronous reset while in GAP
        $display("async reset during GAP");
        setup_model(vt[0], 1'b0);
        n_samples = 8'd2;
        gap_cfg   = 4'd2;
        l0        = launches;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (launches == l0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("rst_test_launch_seen", launches - l0, 1);
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_pg_tog", int'(pg_tog), 1);
        d0  = dones;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_pg_tog", int'(pg_tog), 0);
        chk("arst_hw_min", int'(hw_min), 0);
        chk("arst_launch", int'(clk_launch | clk_capture | val_in), 0);
        chk("arst_done", int'(done), 0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_done", dones - d0, 0);
        chk("arst_still_idle", int'(busy), 0);

        // Table-driven runs
        for (int i = 0; i < 7; i++) begin
            do_run(vt[i], 1'b0, 1'b0);
        end

        // Start pulses while busy plus a stray val_out in every GAP
        do_run(vt[0], 1'b1, 1'b1);

        // Drop en during WAIT of sample 2 of 3
        $display("en drop during WAIT of sample 2");
        vt[0].n   = 3;
        vt[0].g   = 1;
        vt[0].lat = 4;
        vt[0].h0  = 9;
        vt[0].h1  = 8;
        vt[0].h2  = 7;
        setup_model(vt[0], 1'b0);
        n_samples = 8'd3;
        gap_cfg   = 4'd1;
        c0        = captures;
        d0        = dones;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (captures < c0 + 2 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("en_test_second_capture", captures - c0, 2);
        tick();
        en = 1'b0;
        tick();
        chk("en_drop_busy", int'(busy), 0);
        chk("en_drop_n_got", int'(n_got), 1);
        chk("en_drop_sum", int'(sum), 9);
        chk("en_drop_err", int'(err_timeout), 0);
        chk("en_drop_launch", int'(clk_launch | clk_capture | val_in), 0);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        chk("en_drop_no_done", dones - d0, 0);
        chk("en_drop_n_got_held", int'(n_got), 1);
        chk("en_drop_still_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
